// File: rtl/rf_wb_scheduler_if.sv
// Writeback request bus shared by the execute units and the scheduler.
// Ports: valid/addr/data from requesters (master), one-hot ready from arbiter (slave).
interface rf_wb_scheduler_if #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [NREQ-1:0]      valid;
    logic [NREQ-1:0]      ready;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ*XLEN-1:0] data;

    modport master (
        output valid,
        output addr,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  addr,
        input  data,
        output ready
    );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Round-robin writeback arbiter, registered RF write stage, pending-write scoreboard.
// Ports: clk, rst_n, wb (request bus), rf_we/waddr/wdata, issue_*, rs1/rs2 busy, busy_mask.
module rf_wb_scheduler #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    rf_wb_scheduler_if.slave    wb,
    output logic                rf_we,
    output logic [AW-1:0]       rf_waddr,
    output logic [XLEN-1:0]     rf_wdata,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic                issue_ready,
    input  logic [AW-1:0]       rs1_addr,
    input  logic [AW-1:0]       rs2_addr,
    output logic                rs1_busy,
    output logic                rs2_busy,
    output logic [(1<<AW)-1:0]  busy_mask
);
    localparam int NREG = 1 << AW;
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]     r_rr_ptr;
    logic              r_we;
    logic [AW-1:0]     r_waddr;
    logic [XLEN-1:0]   r_wdata;
    logic [NREG-1:0]   r_busy;

    logic [NREQ-1:0]   w_grant;
    logic [PW-1:0]     w_gidx;
    logic              w_any;
    logic [PW-1:0]     w_ptr_next;
    logic              w_issue_fire;
    logic [NREG-1:0]   w_busy_next;
    int                v_idx;

    // Scan from rr_ptr upward, wrapping; the first valid requester wins.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_any   = 1'b0;
        v_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NREQ) begin
                v_idx = v_idx - NREQ;
            end
            if (!w_any && wb.valid[v_idx]) begin
                w_any          = 1'b1;
                w_gidx         = PW'(v_idx);
                w_grant[v_idx] = 1'b1;
            end
        end
        // A grant while held in reset would be lost, so none is offered.
        if (!rst_n) begin
            w_grant = '0;
            w_any   = 1'b0;
        end
    end

    assign wb.ready   = w_grant;
    assign w_ptr_next = (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else begin
            r_we <= w_any;
            if (w_any) begin
                r_rr_ptr <= w_ptr_next;
                r_waddr  <= wb.addr[w_gidx*AW +: AW];
                r_wdata  <= wb.data[w_gidx*XLEN +: XLEN];
            end
        end
    end

    assign rf_we    = r_we;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;

    // A register committing this cycle already reads as free: the RF
    // bypasses the write, and a re-issue may claim it in the same edge.
    assign issue_ready = (issue_rd == '0) | ~r_busy[issue_rd]
                       | (r_we & (r_waddr == issue_rd));
    assign rs1_busy = (rs1_addr != '0) & r_busy[rs1_addr]
                    & ~(r_we & (r_waddr == rs1_addr));
    assign rs2_busy = (rs2_addr != '0) & r_busy[rs2_addr]
                    & ~(r_we & (r_waddr == rs2_addr));
    assign busy_mask    = r_busy;
    assign w_issue_fire = issue_valid & issue_ready;

    // Clear first, then set, so a same-edge set of the committing reg wins.
    always_comb begin
        w_busy_next = r_busy;
        if (r_we) begin
            w_busy_next[r_waddr] = 1'b0;
        end
        if (w_issue_fire && (issue_rd != '0)) begin
            w_busy_next[issue_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Randomised and directed bench for rf_wb_scheduler against a behavioural model.
// Ports: drives the wb interface, issue and source ports; checks every output.
module tb_rf_wb_scheduler;
    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            issue_ready;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic            rs1_busy;
    logic            rs2_busy;
    logic [31:0]     busy_mask;

    int checks   = 0;
    int failures = 0;

    rf_wb_scheduler_if #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) wbi ();

    rf_wb_scheduler #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb         (wbi),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_ready(issue_ready),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .busy_mask  (busy_mask)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_ptr;
    bit          m_busy[32];
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    function automatic logic [2:0] exp_ready();
        int i;
        if (!rst_n) return 3'b000;
        for (int k = 0; k < NREQ; k++) begin
            i = (m_ptr + k) % NREQ;
            if (wbi.valid[i]) return 3'(1 << i);
        end
        return 3'b000;
    endfunction

    function automatic bit exp_issue_ready(logic [4:0] rd);
        return (rd == 0) || !m_busy[rd] || (m_we && m_waddr == rd);
    endfunction

    function automatic bit exp_rs_busy(logic [4:0] a);
        return (a != 0) && m_busy[a] && !(m_we && m_waddr == a);
    endfunction

    function automatic logic [31:0] exp_mask();
        logic [31:0] v;
        for (int r = 0; r < 32; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_we = 0;
        m_waddr = 0;
        m_wdata = 0;
        for (int r = 0; r < 32; r++) m_busy[r] = 0;
    endtask

    // Advance one clock and apply the spec's rules to the model.
    task automatic tick();
        logic [2:0] g;
        bit fire;
        int gi;
        g = exp_ready();
        fire = issue_valid && exp_issue_ready(issue_rd);
        gi = -1;
        for (int i = 0; i < NREQ; i++) if (g[i]) gi = i;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_we) m_busy[m_waddr] = 0;
            if (fire && issue_rd != 0) m_busy[issue_rd] = 1;
            m_busy[0] = 0;
            if (gi >= 0) begin
                m_we = 1;
                m_waddr = wbi.addr[gi*AW +: AW];
                m_wdata = wbi.data[gi*XLEN +: XLEN];
                m_ptr = (gi + 1) % NREQ;
            end else begin
                m_we = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        wbi.valid = '0;
        wbi.addr = '0;
        wbi.data = '0;
        issue_valid = 0;
        issue_rd = 0;
        rs1_addr = 0;
        rs2_addr = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        wbi.valid = 3'b111;
        issue_valid = 1;
        issue_rd = 9;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (wbi.ready !== 3'b000 || rf_we !== 1'b0 || busy_mask !== 32'h0
                || issue_ready !== 1'b1) begin
                failures++;
                $display("FAIL reset: ready=%b we=%b mask=%h irdy=%b want 000 0 0 1",
                         wbi.ready, rf_we, busy_mask, issue_ready);
            end
            tick();
        end
        idle_inputs();
        rst_n = 1;
        #1;
    endtask

    task automatic test_round_robin();
        logic [2:0] want [6];
        want = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        wbi.valid = 3'b111;
        for (int i = 0; i < NREQ; i++) begin
            wbi.addr[i*AW +: AW] = AW'(i + 1);
            wbi.data[i*XLEN +: XLEN] = 32'h100 + i;
        end
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (wbi.ready !== want[c]) begin
                failures++;
                $display("FAIL rr_grant%0d: got %b want %b", c, wbi.ready, want[c]);
            end
            if (c > 0) begin
                checks++;
                if (rf_we !== 1'b1 || rf_waddr !== m_waddr) begin
                    failures++;
                    $display("FAIL rr_write%0d: we=%b addr=%0d want 1 %0d",
                             c, rf_we, rf_waddr, m_waddr);
                end
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_latency();
        wbi.valid = 3'b010;
        wbi.addr[1*AW +: AW] = 5'd5;
        wbi.data[1*XLEN +: XLEN] = 32'hDEADBEEF;
        #1;
        checks++;
        if (wbi.ready !== 3'b010) begin
            failures++;
            $display("FAIL lat_grant: got %b want 010", wbi.ready);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL lat_write: we=%b addr=%0d data=%h want 1 5 deadbeef",
                     rf_we, rf_waddr, rf_wdata);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL lat_idle: we=%b addr=%0d data=%h want 0 5 deadbeef",
                     rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_scoreboard();
        issue_valid = 1;
        issue_rd = 7;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL sb_issue: irdy=%b want 1", issue_ready);
        end
        tick();
        issue_valid = 0;
        rs1_addr = 7;
        #1;
        checks++;
        if (busy_mask[7] !== 1'b1 || rs1_busy !== 1'b1 || issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL sb_busy: mask7=%b rs1=%b irdy=%b want 1 1 0",
                     busy_mask[7], rs1_busy, issue_ready);
        end
        wbi.valid = 3'b001;
        wbi.addr[0 +: AW] = 5'd7;
        wbi.data[0 +: XLEN] = 32'h77;
        tick();
        wbi.valid = '0;
        #1;
        checks++;
        if (rf_we !== 1'b1 || rs1_busy !== 1'b0 || busy_mask[7] !== 1'b1) begin
            failures++;
            $display("FAIL sb_commit: we=%b rs1=%b mask7=%b want 1 0 1",
                     rf_we, rs1_busy, busy_mask[7]);
        end
        tick();
        checks++;
        if (busy_mask[7] !== 1'b0) begin
            failures++;
            $display("FAIL sb_clear: mask7=%b want 0", busy_mask[7]);
        end
        idle_inputs();
    endtask

    task automatic test_race();
        issue_valid = 1;
        issue_rd = 7;
        tick();
        issue_valid = 0;
        wbi.valid = 3'b100;
        wbi.addr[2*AW +: AW] = 5'd7;
        tick();
        wbi.valid = '0;
        issue_valid = 1;
        issue_rd = 7;
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL race_issue: we=%b addr=%0d irdy=%b want 1 7 1",
                     rf_we, rf_waddr, issue_ready);
        end
        tick();
        issue_valid = 0;
        checks++;
        if (busy_mask[7] !== 1'b1) begin
            failures++;
            $display("FAIL race_set: mask7=%b want 1", busy_mask[7]);
        end
        wbi.valid = 3'b001;
        wbi.addr[0 +: AW] = 5'd7;
        tick();
        wbi.valid = '0;
        tick();
        idle_inputs();
    endtask

    task automatic test_x0();
        issue_valid = 1;
        issue_rd = 0;
        tick();
        issue_valid = 0;
        #1;
        checks++;
        if (busy_mask !== 32'h0 || issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL x0_issue: mask=%h irdy=%b want 0 1", busy_mask, issue_ready);
        end
        wbi.valid = 3'b010;
        wbi.addr[1*AW +: AW] = 5'd0;
        wbi.data[1*XLEN +: XLEN] = 32'h1234;
        tick();
        wbi.valid = '0;
        rs1_addr = 0;
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd0 || busy_mask !== 32'h0
            || rs1_busy !== 1'b0 || issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL x0_write: we=%b addr=%0d mask=%h rs1=%b irdy=%b want 1 0 0 0 1",
                     rf_we, rf_waddr, busy_mask, rs1_busy, issue_ready);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        logic [2:0] g;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!wbi.valid[i] && ($urandom_range(1, 0) == 1)) begin
                    wbi.valid[i] = 1'b1;
                    wbi.addr[i*AW +: AW] = AW'($urandom_range(7, 0));
                    wbi.data[i*XLEN +: XLEN] = $urandom;
                end
            end
            issue_valid = ($urandom_range(2, 0) == 0);
            issue_rd = AW'($urandom_range(7, 0));
            rs1_addr = AW'($urandom_range(7, 0));
            rs2_addr = AW'($urandom_range(7, 0));
            #1;
            g = exp_ready();
            checks++;
            if (wbi.ready !== g || issue_ready !== exp_issue_ready(issue_rd)
                || rs1_busy !== exp_rs_busy(rs1_addr)
                || rs2_busy !== exp_rs_busy(rs2_addr)
                || busy_mask !== exp_mask() || rf_we !== m_we
                || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
                failures++;
                $display("FAIL rand%0d: rdy=%b/%b irdy=%b/%b rs=%b%b/%b%b mask=%h/%h we=%b/%b a=%0d/%0d d=%h/%h",
                         c, wbi.ready, g, issue_ready, exp_issue_ready(issue_rd),
                         rs1_busy, rs2_busy, exp_rs_busy(rs1_addr), exp_rs_busy(rs2_addr),
                         busy_mask, exp_mask(), rf_we, m_we, rf_waddr, m_waddr,
                         rf_wdata, m_wdata);
            end
            tick();
            wbi.valid = wbi.valid & ~g;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        issue_valid = 1;
        issue_rd = 3;
        wbi.valid = 3'b001;
        wbi.addr[0 +: AW] = 5'd4;
        tick();
        idle_inputs();
        rst_n = 0;
        #1;
        checks++;
        if (busy_mask !== 32'h0 || rf_we !== 1'b0 || rf_waddr !== 5'd0) begin
            failures++;
            $display("FAIL reset_mid: mask=%h we=%b addr=%0d want 0 0 0",
                     busy_mask, rf_we, rf_waddr);
        end
        tick();
        rst_n = 1;
        #1;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_latency();
        test_scoreboard();
        test_race();
        test_x0();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
